// File: rtl/countdown_timer.sv
// Six-digit BCD (MM:SS:cc) preset countdown timer with start/stop/load control.
// Optional periodic reload on expiry: define COUNTDOWN_AUTORELOAD_EN.
module countdown_timer #(
  parameter int CLK_DIV = 500000,
  parameter int DIV_W   = 19
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        start,
  input  logic        stop,
  input  logic [23:0] preset,
  output logic [3:0]  a,
  output logic [3:0]  b,
  output logic [3:0]  c,
  output logic [3:0]  d,
  output logic [3:0]  e,
  output logic [3:0]  f,
  output logic        running,
  output logic        expired
);

  // state | meaning
  // IDLE  | preset loaded (or reset), waiting for start
  // RUN   | prescaler counting, digits decrement on each tick
  // PAUSE | digits frozen, waiting for start to resume
  // DONE  | count reached zero, held until load or reset
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam logic [DIV_W-1:0] TERM = DIV_W'(CLK_DIV - 1);

  state_t           state_q, state_d;
  logic [23:0]      cnt_q, cnt_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             running_q, running_d;
  logic             expired_q, expired_d;
`ifdef COUNTDOWN_AUTORELOAD_EN
  logic [23:0]      hold_q, hold_d;
`endif

  logic             tick;
  logic [23:0]      dec_val;
  logic [23:0]      pre_clamped;

  function automatic logic [3:0] sat(input logic [3:0] v, input logic [3:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic logic [23:0] clamp_bcd(input logic [23:0] v);
    return {sat(v[23:20], 4'd5), sat(v[19:16], 4'd9),
            sat(v[15:12], 4'd5), sat(v[11:8],  4'd9),
            sat(v[7:4],   4'd9), sat(v[3:0],   4'd9)};
  endfunction

  // Borrow ripples from f upward; digits 3 (c) and 5 (a) wrap to 5, the rest to 9.
  function automatic logic [23:0] dec_bcd(input logic [23:0] v);
    logic [23:0] r;
    logic        borrow;
    logic [3:0]  dig;
    logic [3:0]  lim;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dig = v[i*4 +: 4];
      lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
      if (borrow) begin
        if (dig == 4'd0) begin
          r[i*4 +: 4] = lim;
        end else begin
          r[i*4 +: 4] = dig - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign tick        = (state_q == RUN) && (presc_q == TERM);
  assign dec_val     = dec_bcd(cnt_q);
  assign pre_clamped = clamp_bcd(preset);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    presc_d   = '0;
    expired_d = 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
    hold_d    = hold_q;
`endif

    if (load) begin
      cnt_d   = pre_clamped;
`ifdef COUNTDOWN_AUTORELOAD_EN
      hold_d  = pre_clamped;
`endif
      state_d = IDLE;
    end else if (start && (state_q == IDLE || state_q == PAUSE)) begin
      if (cnt_q == '0) begin
        state_d   = DONE;
        expired_d = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else if (state_q == RUN) begin
      if (tick) begin
        if (dec_val == '0) begin
          expired_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
          if (hold_q != '0) begin
            cnt_d = hold_q;
          end else begin
            cnt_d   = '0;
            state_d = DONE;
          end
`else
          cnt_d   = '0;
          state_d = DONE;
`endif
        end else begin
          cnt_d = dec_val;
        end
      end
      // a start strobe in RUN outranks stop even though it does nothing itself
      if (stop && !start && state_d == RUN) begin
        state_d = PAUSE;
      end
    end

    if (state_q == RUN && state_d == RUN) begin
      presc_d = tick ? '0 : presc_q + DIV_W'(1);
    end

    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      presc_q   <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      presc_q   <= presc_d;
      running_q <= running_d;
      expired_q <= expired_d;
    end
  end

`ifdef COUNTDOWN_AUTORELOAD_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`endif

  assign a       = cnt_q[23:20];
  assign b       = cnt_q[19:16];
  assign c       = cnt_q[15:12];
  assign d       = cnt_q[11:8];
  assign e       = cnt_q[7:4];
  assign f       = cnt_q[3:0];
  assign running = running_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: vector table, directed sequences,
// and random control strobes against a centisecond-arithmetic reference model.
module tb_countdown_timer;

  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [23:0] preset = '0;
  logic [3:0]  a, b, c, d, e, f;
  logic        running, expired;
  logic [23:0] digits;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  countdown_timer #(.CLK_DIV(CLK_DIV), .DIV_W(3)) dut (
    .clk(clk), .reset(reset), .load(load), .start(start), .stop(stop),
    .preset(preset), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
    .running(running), .expired(expired)
  );

  assign digits = {a, b, c, d, e, f};

  typedef struct {
    logic        ld;
    logic        st;
    logic        sp;
    logic [23:0] pre;
    logic [23:0] exp_dig;
    logic        exp_run;
    logic        exp_exp;
  } vec_t;

  vec_t tbl[$];

  // reference model: count held as total centiseconds
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int m_mode, m_phase, m_total, m_hold;
  bit m_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic ld, input logic st, input logic sp, input logic [23:0] pre);
    @(negedge clk);
    load = ld; start = st; stop = sp; preset = pre;
    @(posedge clk);
    #1;
    load = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  function automatic int to_cs(input logic [23:0] p);
    int na, nb, nc, nd, ne, nf;
    na = (p[23:20] > 4'd5) ? 5 : int'(p[23:20]);
    nb = (p[19:16] > 4'd9) ? 9 : int'(p[19:16]);
    nc = (p[15:12] > 4'd5) ? 5 : int'(p[15:12]);
    nd = (p[11:8]  > 4'd9) ? 9 : int'(p[11:8]);
    ne = (p[7:4]   > 4'd9) ? 9 : int'(p[7:4]);
    nf = (p[3:0]   > 4'd9) ? 9 : int'(p[3:0]);
    return (na * 10 + nb) * 6000 + (nc * 10 + nd) * 100 + ne * 10 + nf;
  endfunction

  function automatic logic [23:0] to_bcd(input int t);
    int mm, ss, cc;
    mm = t / 6000;
    ss = (t / 100) % 60;
    cc = t % 100;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_phase = 0; m_total = 0; m_hold = 0; m_exp = 0;
  endtask

  task automatic model_step(input bit ld, input bit st, input bit sp, input logic [23:0] pre);
    m_exp = 0;
    if (ld) begin
      m_total = to_cs(pre);
      m_hold  = m_total;
      m_mode  = M_IDLE;
      m_phase = 0;
    end else if (st && (m_mode == M_IDLE || m_mode == M_PAUSE)) begin
      if (m_total == 0) begin
        m_mode = M_DONE;
        m_exp  = 1;
      end else begin
        m_mode  = M_RUN;
        m_phase = 0;
      end
    end else if (m_mode == M_RUN) begin
      m_phase++;
      if (m_phase == CLK_DIV) begin
        m_phase = 0;
        m_total--;
        if (m_total == 0) begin
          m_exp = 1;
`ifdef COUNTDOWN_AUTORELOAD_EN
          if (m_hold != 0) m_total = m_hold;
          else m_mode = M_DONE;
`else
          m_mode = M_DONE;
`endif
        end
      end
      if (sp && !st && m_mode == M_RUN) m_mode = M_PAUSE;
    end
  endtask

  function automatic logic [23:0] bcd2(input int n);
    return {16'h0, 4'(n / 10), 4'(n % 10)};
  endfunction

  initial begin
    int cyc;
    logic [23:0] pre;
    bit ld, st, sp;

    // reset held
    repeat (3) @(posedge clk);
    #1;
    chk("reset_digits", 32'(digits), 32'h0);
    chk("reset_running", 32'(running), 32'h0);
    chk("reset_expired", 32'(expired), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    //                ld    st    sp    preset       digits       run   exp
    tbl.push_back('{1'b0, 1'b1, 1'b0, 24'h000000, 24'h000000, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 24'h000000, 24'h000000, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 24'h000000, 24'h000000, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 24'hFFFFFF, 24'h595999, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 24'h010000, 24'h010000, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 24'h000000, 24'h010000, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 24'h000000, 24'h010000, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 24'h000000, 24'h010000, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 24'h000000, 24'h010000, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 24'h000000, 24'h005999, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 24'h000000, 24'h005999, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 24'h000000, 24'h005999, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 24'h000000, 24'h005999, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 24'h000000, 24'h005998, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 24'h000000, 24'h005998, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 24'h000000, 24'h005998, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 24'h000000, 24'h005998, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 24'h000000, 24'h005998, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 24'h000000, 24'h005998, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 24'h000000, 24'h005997, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 24'h9A0A0A, 24'h590909, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 24'h000003, 24'h000003, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 24'h000000, 24'h000003, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 24'h000000, 24'h000000, 1'b0, 1'b0});

    foreach (tbl[i]) begin
      step(tbl[i].ld, tbl[i].st, tbl[i].sp, tbl[i].pre);
      chk($sformatf("vec%0d_digits", i), 32'(digits), 32'(tbl[i].exp_dig));
      chk($sformatf("vec%0d_running", i), 32'(running), 32'(tbl[i].exp_run));
      chk($sformatf("vec%0d_expired", i), 32'(expired), 32'(tbl[i].exp_exp));
    end

    // full countdown from 12 at 4-cycle spacing
    step(1'b1, 1'b0, 1'b0, 24'h000012);
    chk("cd_load", 32'(digits), 32'h12);
    step(1'b0, 1'b1, 1'b0, 24'h0);
    chk("cd_running", 32'(running), 32'h1);
    for (int n = 11; n >= 0; n--) begin
      for (int k = 0; k < CLK_DIV - 1; k++) begin
        step(1'b0, 1'b0, 1'b0, 24'h0);
        chk($sformatf("cd_hold%0d", n), 32'({digits, expired}), 32'({bcd2(n + 1), 1'b0}));
      end
      step(1'b0, 1'b0, 1'b0, 24'h0);
`ifdef COUNTDOWN_AUTORELOAD_EN
      chk($sformatf("cd_dig%0d", n), 32'(digits), 32'(n == 0 ? 24'h12 : bcd2(n)));
      chk($sformatf("cd_run%0d", n), 32'(running), 32'h1);
`else
      chk($sformatf("cd_dig%0d", n), 32'(digits), 32'(bcd2(n)));
      chk($sformatf("cd_run%0d", n), 32'(running), 32'(n != 0));
`endif
      chk($sformatf("cd_exp%0d", n), 32'(expired), 32'(n == 0));
    end
    step(1'b0, 1'b0, 1'b0, 24'h0);
    chk("cd_exp_single", 32'(expired), 32'h0);

`ifdef COUNTDOWN_AUTORELOAD_EN
    step(1'b1, 1'b0, 1'b0, 24'h000002);
    step(1'b0, 1'b1, 1'b0, 24'h0);
    for (int p = 0; p < 4; p++) begin
      repeat (CLK_DIV - 1) step(1'b0, 1'b0, 1'b0, 24'h0);
      step(1'b0, 1'b0, 1'b0, 24'h0);
      chk($sformatf("ar_dig%0d", p), 32'(digits), 32'((p % 2 == 0) ? 24'h1 : 24'h2));
      chk($sformatf("ar_exp%0d", p), 32'(expired), 32'(p % 2 == 1));
      chk($sformatf("ar_run%0d", p), 32'(running), 32'h1);
    end
`endif

    // pause / resume
    step(1'b1, 1'b0, 1'b0, 24'h000005);
    step(1'b0, 1'b1, 1'b0, 24'h0);
    repeat (CLK_DIV) step(1'b0, 1'b0, 1'b0, 24'h0);
    chk("pr_first_tick", 32'(digits), 32'h4);
    step(1'b0, 1'b0, 1'b1, 24'h0);
    chk("pr_paused", 32'(running), 32'h0);
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b0, 1'b0, 24'h0);
      chk($sformatf("pr_hold%0d", k), 32'({digits, running}), 32'({24'h4, 1'b0}));
    end
    step(1'b0, 1'b1, 1'b0, 24'h0);
    chk("pr_resumed", 32'(running), 32'h1);
    cyc = 0;
    while (digits == 24'h4 && cyc < 10) begin
      step(1'b0, 1'b0, 1'b0, 24'h0);
      cyc++;
    end
    chk("pr_resume_latency", 32'(cyc), 32'(CLK_DIV));
    chk("pr_resume_digits", 32'(digits), 32'h3);

    // asynchronous reset mid-count
    step(1'b1, 1'b0, 1'b0, 24'h000050);
    step(1'b0, 1'b1, 1'b0, 24'h0);
    repeat (6) step(1'b0, 1'b0, 1'b0, 24'h0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_digits", 32'(digits), 32'h0);
    chk("async_rst_running", 32'(running), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();

    // random strobes against the reference model
    for (int i = 0; i < 3000; i++) begin
      ld  = ($urandom_range(0, 49) == 0);
      st  = ($urandom_range(0, 9) == 0);
      sp  = ($urandom_range(0, 11) == 0);
      pre = ($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'($urandom_range(0, 20));
      step(ld, st, sp, pre);
      model_step(ld, st, sp, pre);
      chk($sformatf("rnd%0d_digits", i), 32'(digits), 32'(to_bcd(m_total)));
      chk($sformatf("rnd%0d_running", i), 32'(running), 32'(m_mode == M_RUN));
      chk($sformatf("rnd%0d_expired", i), 32'(expired), 32'(m_exp));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
